// File: rtl/adder_accum_if.sv
// adder_accum_if: sample input, frame-sum output handshake and overrun control for adder_accum.
//   i_valid/i_C      sample strobe and unsigned sample (g_data_width+1 bits)
//   i_ready          downstream accepts o_sum this cycle
//   i_clr_overrun    clears the sticky overrun flag
//   o_valid/o_sum    held frame sum awaiting acceptance (g_acc_width bits)
//   o_overrun        sticky: a completed frame was dropped
//   o_sat            frame sum was clamped (saturating build only)
interface adder_accum_if #(
    parameter int g_data_width = 8,
    parameter int g_acc_width  = 11
);
    logic                    i_valid;
    logic [g_data_width:0]   i_C;
    logic                    i_ready;
    logic                    i_clr_overrun;
    logic                    o_valid;
    logic [g_acc_width-1:0]  o_sum;
    logic                    o_overrun;
    logic                    o_sat;
    modport master(output i_valid, i_C, i_ready, i_clr_overrun, input o_valid, o_sum, o_overrun, o_sat);
    modport slave(input i_valid, i_C, i_ready, i_clr_overrun, output o_valid, o_sum, o_overrun, o_sat);
endinterface

// File: rtl/adder_accum.sv
// adder_accum: sums g_frame_len valid samples per frame into a single-entry valid/ready holding register.
//   i_clk  clock, rising edge
//   i_rst  asynchronous active-high reset
//   bus    adder_accum_if.slave (sample in, frame sum out, overrun/sat flags)
//   Define ACCUM_SAT_EN for saturating adds with o_sat; otherwise adds wrap and o_sat is 0.
module adder_accum #(
    parameter int g_data_width = 8,
    parameter int g_frame_len  = 4,
    parameter int g_acc_width  = 11
) (
    input logic          i_clk,
    input logic          i_rst,
    adder_accum_if.slave bus
);
    localparam int CW = g_frame_len > 1 ? $clog2(g_frame_len) : 1;
    logic [g_acc_width-1:0] acc, add_res, sum_q;
    logic [CW-1:0]          cnt;
    logic                   frame_end, load, drop, valid_q, overrun_q;
    assign frame_end = bus.i_valid && cnt == CW'(g_frame_len - 1);
    // the slot can take a new sum when empty or being emptied this cycle
    assign load      = frame_end && (!valid_q || bus.i_ready);
    assign drop      = frame_end && valid_q && !bus.i_ready;
`ifdef ACCUM_SAT_EN
    localparam int SW = (g_acc_width > g_data_width + 1 ? g_acc_width : g_data_width + 1) + 1;
    logic [SW-1:0] sum_full;
    logic          ovf, sat_acc, sat_q;
    always_comb begin
        sum_full = SW'(acc) + SW'(bus.i_C);
        ovf      = |sum_full[SW-1:g_acc_width];
        add_res  = ovf ? '1 : sum_full[g_acc_width-1:0];
    end
    // sat_acc remembers a clamp earlier in the frame; cleared at frame end so each frame starts clean
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sat_acc <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            sat_acc <= bus.i_valid ? (frame_end ? 1'b0 : sat_acc | ovf) : sat_acc;
            sat_q   <= load ? sat_acc | ovf : sat_q;
        end
    end
    assign bus.o_sat = sat_q;
`else
    assign add_res   = acc + g_acc_width'(bus.i_C);
    assign bus.o_sat = 1'b0;
`endif
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            acc       <= '0;
            cnt       <= '0;
            sum_q     <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (bus.i_valid) begin
                acc <= frame_end ? '0 : add_res;
                cnt <= frame_end ? '0 : cnt + 1'b1;
            end
            sum_q     <= load ? add_res : sum_q;
            valid_q   <= load ? 1'b1 : (valid_q && bus.i_ready ? 1'b0 : valid_q);
            // a drop in the same cycle as a clear leaves the flag set
            overrun_q <= drop || (overrun_q && !bus.i_clr_overrun);
        end
    end
    assign bus.o_valid   = valid_q;
    assign bus.o_sum     = sum_q;
    assign bus.o_overrun = overrun_q;
endmodule

// File: tb/tb_adder_accum.sv
// tb_adder_accum: scenario and randomized checks of adder_accum against a frame-level model.
module tb_adder_accum;
    localparam int DW = 8, FL = 4, AW = 11, AW9 = 9;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;
    adder_accum_if #(.g_data_width(DW), .g_acc_width(AW)) bus();
    adder_accum_if #(.g_data_width(DW), .g_acc_width(AW9)) bus9();
    adder_accum #(.g_data_width(DW), .g_frame_len(FL), .g_acc_width(AW)) dut (.i_clk(clk), .i_rst(rst), .bus(bus.slave));
    adder_accum #(.g_data_width(DW), .g_frame_len(FL), .g_acc_width(AW9)) dut9 (.i_clk(clk), .i_rst(rst), .bus(bus9.slave));
    int n_checks = 0, n_fail = 0;
    int m_cnt, m_sum;
    longint m_true;
    bit m_valid, m_ovr, m_sat;
    bit sat_build;
    function automatic void model_reset();
        m_cnt = 0; m_true = 0; m_sum = 0; m_valid = 0; m_ovr = 0; m_sat = 0;
    endfunction
    // frame-level view: exact sum of the frame, then wrap or clamp once
    function automatic void model_edge(bit v, int c, bit r, bit clr);
        longint t = m_true + (v ? c : 0);
        longint mx = (longint'(1) << AW) - 1;
        bit fe = v && m_cnt == FL - 1;
        bit ld = fe && (!m_valid || r);
        m_ovr = (fe && !ld) || (m_ovr && !clr);
        if (ld) begin
            m_sum = sat_build ? int'(t > mx ? mx : t) : int'(t % (mx + 1));
            m_sat = sat_build && t > mx;
            m_valid = 1;
        end else if (m_valid && r) m_valid = 0;
        if (fe) begin m_true = 0; m_cnt = 0; end
        else if (v) begin m_true = t; m_cnt++; end
    endfunction
    task automatic cyc(bit v, int c, bit r, bit clr);
        bus.i_valid = v; bus.i_C = 9'(c); bus.i_ready = r; bus.i_clr_overrun = clr;
        model_edge(v, c, r, clr);
        @(posedge clk); #1;
    endtask
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks += 4;
        if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", bus.o_valid); end
        if (bus.o_sum !== '0) begin n_fail++; $display("FAIL reset_sum got %0d want 0", bus.o_sum); end
        if (bus.o_overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got %0b want 0", bus.o_overrun); end
        if (bus.o_sat !== 1'b0) begin n_fail++; $display("FAIL reset_sat got %0b want 0", bus.o_sat); end
        rst = 1'b0;
        model_reset();
    endtask
    task automatic test_basic();
        for (int i = 1; i <= 3; i++) cyc(1, i, 1, 0);
        n_checks++;
        if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid got %0b want 0", bus.o_valid); end
        cyc(1, 4, 1, 0);
        n_checks += 2;
        if (bus.o_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %0b want 1", bus.o_valid); end
        if (bus.o_sum !== 11'd10) begin n_fail++; $display("FAIL basic_sum got %0d want 10", bus.o_sum); end
        cyc(0, 0, 1, 0);
        n_checks += 2;
        if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL basic_accept got %0b want 0", bus.o_valid); end
        if (bus.o_sum !== 11'd10) begin n_fail++; $display("FAIL basic_sum_keep got %0d want 10", bus.o_sum); end
    endtask
    task automatic test_idle_gaps();
        for (int i = 0; i < 4; i++) begin
            if (i > 0) repeat ($urandom_range(0, 3)) cyc(0, 0, 1, 0);
            n_checks++;
            if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL gaps_valid_early got %0b want 0", bus.o_valid); end
            cyc(1, 510, 1, 0);
        end
        n_checks += 2;
        if (bus.o_valid !== 1'b1) begin n_fail++; $display("FAIL gaps_valid got %0b want 1", bus.o_valid); end
        if (bus.o_sum !== 11'd2040) begin n_fail++; $display("FAIL gaps_sum got %0d want 2040", bus.o_sum); end
        cyc(0, 0, 1, 0);
    endtask
    task automatic test_overrun();
        for (int i = 1; i <= 4; i++) cyc(1, i, 0, 0);
        repeat (4) cyc(1, 5, 0, 0);
        n_checks += 3;
        if (bus.o_overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set got %0b want 1", bus.o_overrun); end
        if (bus.o_sum !== 11'd10) begin n_fail++; $display("FAIL ovr_sum_hold got %0d want 10", bus.o_sum); end
        if (bus.o_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_valid_hold got %0b want 1", bus.o_valid); end
        cyc(0, 0, 1, 0);
        n_checks += 2;
        if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_accept got %0b want 0", bus.o_valid); end
        if (bus.o_overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky got %0b want 1", bus.o_overrun); end
        cyc(0, 0, 1, 1);
        n_checks++;
        if (bus.o_overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear got %0b want 0", bus.o_overrun); end
    endtask
    task automatic test_accept_frame_end();
        for (int i = 1; i <= 4; i++) cyc(1, i, 0, 0);
        repeat (3) cyc(1, 6, 0, 0);
        cyc(1, 6, 1, 0);
        n_checks += 3;
        if (bus.o_sum !== 11'd24) begin n_fail++; $display("FAIL b2b_sum got %0d want 24", bus.o_sum); end
        if (bus.o_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid got %0b want 1", bus.o_valid); end
        if (bus.o_overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_overrun got %0b want 0", bus.o_overrun); end
        cyc(0, 0, 1, 0);
    endtask
    task automatic test_wrap();
        bus9.i_ready = 1; bus9.i_clr_overrun = 0;
        for (int i = 0; i < 4; i++) begin
            bus9.i_valid = 1; bus9.i_C = 9'd200;
            @(posedge clk); #1;
        end
        bus9.i_valid = 0;
        n_checks += 3;
        if (bus9.o_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_valid got %0b want 1", bus9.o_valid); end
        if (bus9.o_sum !== (sat_build ? 9'd511 : 9'd288)) begin n_fail++; $display("FAIL wrap_sum got %0d want %0d", bus9.o_sum, sat_build ? 511 : 288); end
        if (bus9.o_sat !== sat_build) begin n_fail++; $display("FAIL wrap_sat got %0b want %0b", bus9.o_sat, sat_build); end
    endtask
    task automatic test_reset_mid();
        for (int i = 1; i <= 4; i++) cyc(1, 3, 0, 0);
        repeat (2) cyc(1, 7, 0, 0);
        rst = 1'b1;
        #2;
        n_checks += 4;
        if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid got %0b want 0", bus.o_valid); end
        if (bus.o_sum !== '0) begin n_fail++; $display("FAIL rmid_sum got %0d want 0", bus.o_sum); end
        if (bus.o_overrun !== 1'b0) begin n_fail++; $display("FAIL rmid_overrun got %0b want 0", bus.o_overrun); end
        if (bus.o_sat !== 1'b0) begin n_fail++; $display("FAIL rmid_sat got %0b want 0", bus.o_sat); end
        model_reset();
        bus.i_valid = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) cyc(1, 5, 1, 0);
        n_checks += 2;
        if (bus.o_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_after_valid got %0b want 1", bus.o_valid); end
        if (bus.o_sum !== 11'd20) begin n_fail++; $display("FAIL rmid_after_sum got %0d want 20", bus.o_sum); end
        cyc(0, 0, 1, 0);
    endtask
    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 511), $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);
            n_checks += 4;
            if (bus.o_valid !== m_valid) begin n_fail++; $display("FAIL rand_valid cyc %0d got %0b want %0b", i, bus.o_valid, m_valid); end
            if (bus.o_sum !== 11'(m_sum)) begin n_fail++; $display("FAIL rand_sum cyc %0d got %0d want %0d", i, bus.o_sum, m_sum); end
            if (bus.o_overrun !== m_ovr) begin n_fail++; $display("FAIL rand_overrun cyc %0d got %0b want %0b", i, bus.o_overrun, m_ovr); end
            if (bus.o_sat !== m_sat) begin n_fail++; $display("FAIL rand_sat cyc %0d got %0b want %0b", i, bus.o_sat, m_sat); end
        end
    endtask
    initial begin
`ifdef ACCUM_SAT_EN
        sat_build = 1'b1;
`else
        sat_build = 1'b0;
`endif
        bus.i_valid = 0; bus.i_C = '0; bus.i_ready = 0; bus.i_clr_overrun = 0;
        bus9.i_valid = 0; bus9.i_C = '0; bus9.i_ready = 0; bus9.i_clr_overrun = 0;
        model_reset();
        test_reset();
        test_basic();
        test_idle_gaps();
        test_overrun();
        test_accept_frame_end();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
